// File: rtl/ptf_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// ptf_mem_responder_pkg
// Shared constants for the pixel-fetcher memory responder: coordinate and
// memory widths, the access FSM state encodings, and the helper that packs a
// frame bank and pixel coordinate into an external memory word address.
// ---------------------------------------------------------------------------
package ptf_mem_responder_pkg;

    localparam int LOG_WIDTH  = 10;
    localparam int LOG_HEIGHT = 9;
    localparam int LOG_MEM    = 36;
    localparam int LOG_ADDR   = 19;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DATA = 2'd3;

    // One memory word holds two horizontally adjacent pixels, so the word
    // address uses x without its lowest bit. The bank bit selects one of the
    // two frame buffers.
    function automatic logic [LOG_ADDR-1:0] make_addr(
        input logic                  sel,
        input logic [LOG_HEIGHT-1:0] y,
        input logic [LOG_WIDTH-2:0]  x_word
    );
        return {sel, y, x_word};
    endfunction

endpackage

// File: rtl/ptf_mem_responder.sv
// ---------------------------------------------------------------------------
// ptf_mem_responder
// Arbitrates a single external synchronous SRAM between the pixel fetcher
// (read/write, in frame bank 'bank') and the display (read only, in frame
// bank ~bank). Every access takes four cycles: IDLE -> ADDR -> WAIT -> DATA.
//
// Ports
//   clock, reset         : system clock, synchronous active-high reset
//   ptf_flag, ptf_wr     : fetcher request valid and write/read select
//   ptf_x, ptf_y         : fetcher pixel coordinate
//   ptf_pixel_write      : fetcher write word (two packed pixels)
//   done_ptf             : responder ready / previous fetcher access done
//   ptf_pixel_read       : last word read for the fetcher
//   bank                 : fetcher frame bank; display uses the other one
//   disp_req, disp_x/y   : display read request and coordinate
//   disp_pixel,disp_valid: display read word and its one-cycle strobe
//   mem_addr, mem_we_b   : SRAM address and active-low write enable
//   mem_data_out/_oe     : SRAM write data and its output enable; the
//                          tristate buffer itself lives at the chip top
//   mem_data_in          : SRAM read data
// ---------------------------------------------------------------------------
module ptf_mem_responder
    import ptf_mem_responder_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ptf_flag,
    input  logic                  ptf_wr,
    input  logic [LOG_WIDTH-1:0]  ptf_x,
    input  logic [LOG_HEIGHT-1:0] ptf_y,
    input  logic [LOG_MEM-1:0]    ptf_pixel_write,
    output logic                  done_ptf,
    output logic [LOG_MEM-1:0]    ptf_pixel_read,
    input  logic                  bank,
    input  logic                  disp_req,
    input  logic [LOG_WIDTH-1:0]  disp_x,
    input  logic [LOG_HEIGHT-1:0] disp_y,
    output logic [LOG_MEM-1:0]    disp_pixel,
    output logic                  disp_valid,
    output logic [LOG_ADDR-1:0]   mem_addr,
    output logic                  mem_we_b,
    output logic [LOG_MEM-1:0]    mem_data_out,
    output logic                  mem_data_oe,
    input  logic [LOG_MEM-1:0]    mem_data_in
);

    state_t               state;
    logic                 acc_write;
    logic                 acc_disp;
    logic [LOG_MEM-1:0]   wr_word;
    logic                 accept_disp;
    logic                 accept_ptf;
    logic                 unused_x_lsb;

    // The x LSB selects a pixel inside the word, which the fetcher handles
    // itself; the responder only ever addresses whole words.
    assign unused_x_lsb = ptf_x[0] ^ disp_x[0];

    // Ready is combinational so the fetcher sees it drop in the same cycle a
    // display request shows up; the display always has priority in IDLE.
    assign done_ptf    = (state == ST_IDLE) && !disp_req && !reset;
    assign accept_disp = (state == ST_IDLE) && disp_req;
    assign accept_ptf  = ptf_flag && done_ptf;

    // Access sequencer. The write enable is a single-cycle pulse in ADDR,
    // the write data is driven during DATA, and read data is captured on the
    // edge that leaves DATA. mem_addr is held for the whole access so the
    // SRAM sees a stable address. The display strobe defaults low every
    // cycle so it can only ever be a one-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            mem_we_b       <= 1'b1;
            mem_data_oe    <= 1'b0;
            disp_valid     <= 1'b0;
            mem_addr       <= '0;
            mem_data_out   <= '0;
            ptf_pixel_read <= '0;
            disp_pixel     <= '0;
            acc_write      <= 1'b0;
            acc_disp       <= 1'b0;
            wr_word        <= '0;
        end else begin
            disp_valid <= 1'b0;
            mem_we_b   <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept_disp) begin
                        state     <= ST_ADDR;
                        mem_addr  <= make_addr(~bank, disp_y, disp_x[LOG_WIDTH-1:1]);
                        acc_write <= 1'b0;
                        acc_disp  <= 1'b1;
                    end else if (accept_ptf) begin
                        state     <= ST_ADDR;
                        mem_addr  <= make_addr(bank, ptf_y, ptf_x[LOG_WIDTH-1:1]);
                        mem_we_b  <= ~ptf_wr;
                        acc_write <= ptf_wr;
                        acc_disp  <= 1'b0;
                        wr_word   <= ptf_pixel_write;
                    end
                end
                ST_ADDR: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_DATA;
                    if (acc_write) begin
                        mem_data_out <= wr_word;
                        mem_data_oe  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    state       <= ST_IDLE;
                    mem_data_oe <= 1'b0;
                    if (!acc_write) begin
                        if (acc_disp) begin
                            disp_pixel <= mem_data_in;
                            disp_valid <= 1'b1;
                        end else begin
                            ptf_pixel_read <= mem_data_in;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ptf_mem_responder.md
PTF_MEM_RESPONDER -- requirements
Module: ptf_mem_responder

Interface
REQ-001 Parameters (shared-package constants): LOG_WIDTH=10 (x bits), LOG_HEIGHT=9 (y bits), LOG_MEM=36 (memory word), LOG_ADDR=19 (memory address).
REQ-002 One clock; reset is synchronous and active-high; ports named clock and reset.
REQ-003 clock  in  1  system clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 ptf_flag  in  1  fetcher request valid; fetcher holds it and its fields until acceptance.
REQ-006 ptf_wr  in  1  1 = write word, 0 = read word.
REQ-007 ptf_x / ptf_y  in  LOG_WIDTH / LOG_HEIGHT  pixel coordinate.
REQ-008 ptf_pixel_write  in  LOG_MEM  write word, two packed pixels.
REQ-009 done_ptf  out  1  responder ready; also marks completion of the previous fetcher access.
REQ-010 ptf_pixel_read  out  LOG_MEM  last word read for the fetcher, held until the next fetcher read completes.
REQ-011 bank  in  1  frame bank the fetcher writes; display reads ~bank.
REQ-012 disp_req  in  1  display read request; disp_x / disp_y  in  LOG_WIDTH / LOG_HEIGHT.
REQ-013 disp_pixel  out  LOG_MEM  display word; disp_valid  out  1  one-cycle data strobe.
REQ-014 mem_addr  out  LOG_ADDR; mem_we_b  out  1  active-low write enable; mem_data_out  out  LOG_MEM; mem_data_oe  out  1; mem_data_in  in  LOG_MEM.

Function
REQ-015 Address = {bank_sel, y[8:0], x[9:1]}: bank_sel = bank for fetcher accesses and ~bank for display accesses, sampled at acceptance.
REQ-016 FSM states: IDLE, ADDR, WAIT, DATA; the sequence after acceptance is IDLE->ADDR->WAIT->DATA->IDLE with no stalls.
REQ-017 done_ptf = (state==IDLE) & ~disp_req & ~reset, combinational.
REQ-018 Acceptance at edge E0: disp_req in IDLE always wins; otherwise a fetcher request is accepted when ptf_flag & done_ptf.
REQ-019 At E0, register mem_addr; mem_we_b <= ~wr, where wr=1 only for a fetcher write; latch the write word.
REQ-020 After E1, mem_we_b returns to 1 and mem_addr holds.
REQ-021 Writes only: at E2, mem_data_out <= latched word and mem_data_oe <= 1; at E3, mem_data_oe <= 0.
REQ-022 Reads: at E3, capture mem_data_in into ptf_pixel_read (fetcher) or into disp_pixel with disp_valid=1 for exactly one cycle (display).
REQ-023 At E3 the state returns to IDLE, so done_ptf is high again after E3 and a new acceptance is possible at E3+1.
REQ-024 Fetcher writes leave ptf_pixel_read unchanged.
REQ-025 mem_data_oe is never high during a read access.
REQ-026 disp_req and ptf_flag raised on the same edge: the display is served first and the fetcher is accepted at the first IDLE edge with disp_req low.
REQ-027 Coordinates are not range-checked; the address bits are truncated as in REQ-015.

Reset
REQ-028 While reset is high at an edge: state <= IDLE, mem_we_b <= 1, mem_data_oe <= 0, disp_valid <= 0, mem_addr <= 0, mem_data_out <= 0, ptf_pixel_read <= 0, disp_pixel <= 0.
REQ-029 Reset mid-access aborts the access with no write strobe or data strobe; done_ptf is high in the first cycle after reset deasserts.

Structure
REQ-030 LOG_* constants and FSM state encodings live in the shared defines file used by pt_fetcher and its testbench.
REQ-031 Single flat module; no sub-module is required. Tristate of the memory data bus is done at the top level using mem_data_oe.

Verification
REQ-032 Fetcher write, bank=0, x=123, y=321, data=36'h012345678 -> mem_addr=19'h2823D; mem_we_b low for exactly 1 cycle; the data is driven with mem_data_oe=1 one cycle after E2; done_ptf low for 3 cycles.
REQ-033 Fetcher read, bank=1, x=234, y=432; memory model returns 36'hABCDE0123 -> mem_addr=19'h76075; ptf_pixel_read=36'hABCDE0123 after E3; mem_data_oe never asserted.
REQ-034 disp_req and ptf_flag asserted together, bank=0 -> display read at bank 1 first with one disp_valid pulse; fetcher accepted at E3+1; two complete accesses, no overlap.
REQ-035 Back-to-back fetcher reads with ptf_flag held high -> acceptances exactly 4 cycles apart; ptf_pixel_read updates at each E3.
REQ-036 Reset asserted at E1 of a write -> no mem_data_oe pulse, mem_we_b=1, done_ptf=1 in the cycle after reset; the next request proceeds normally.
